// File: rtl/event_pulse_gen.sv
// Input conditioning for the event counter: synchronizes, debounces and converts
// the raw sensor and load button into single-cycle count_en / load_pulse strobes.
module event_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_in,
  input  logic load_btn,
  input  logic pause,
  output logic count_en,
  output logic load_pulse,
  output logic sensor_level
);

  localparam int SEN = 0;
  localparam int LD  = 1;
  localparam logic [DB_W-1:0] LIMIT = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] ONE   = DB_W'(1);

  typedef enum logic [1:0] {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW} db_state_t;

  logic [1:0]            s1;
  logic [1:0]            s2;
  db_state_t             state     [2];
  db_state_t             state_nxt [2];
  logic [1:0][DB_W-1:0]  cnt;
  logic [1:0][DB_W-1:0]  cnt_nxt;
  logic [1:0]            stable;
  logic [1:0]            stable_nxt;
  logic [1:0]            rise;
  logic                  pending;
  logic                  pending_nxt;
  logic                  count_en_nxt;
  logic                  load_pulse_nxt;

  // Debounce: cnt holds the number of consecutive differing samples already seen,
  // so acceptance happens on the sample that makes the run DEBOUNCE_CYCLES long.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nxt[i]  = state[i];
      cnt_nxt[i]    = cnt[i];
      stable_nxt[i] = stable[i];
      rise[i]       = 1'b0;
      unique case (state[i])
        IDLE_LOW: begin
          if (s2[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt[i]  = IDLE_HIGH;
              stable_nxt[i] = 1'b1;
              rise[i]       = 1'b1;
              cnt_nxt[i]    = LIMIT;
            end else begin
              state_nxt[i] = CHECK_HIGH;
              cnt_nxt[i]   = ONE;
            end
          end
        end
        CHECK_HIGH: begin
          if (!s2[i]) begin
            state_nxt[i] = IDLE_LOW;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] + ONE == LIMIT) begin
            state_nxt[i]  = IDLE_HIGH;
            stable_nxt[i] = 1'b1;
            rise[i]       = 1'b1;
            cnt_nxt[i]    = LIMIT;
          end else begin
            cnt_nxt[i] = cnt[i] + ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s2[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt[i]  = IDLE_LOW;
              stable_nxt[i] = 1'b0;
              cnt_nxt[i]    = LIMIT;
            end else begin
              state_nxt[i] = CHECK_LOW;
              cnt_nxt[i]   = ONE;
            end
          end
        end
        CHECK_LOW: begin
          if (s2[i]) begin
            state_nxt[i] = IDLE_HIGH;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] + ONE == LIMIT) begin
            state_nxt[i]  = IDLE_LOW;
            stable_nxt[i] = 1'b0;
            cnt_nxt[i]    = LIMIT;
          end else begin
            cnt_nxt[i] = cnt[i] + ONE;
          end
        end
        default: begin
          state_nxt[i] = IDLE_LOW;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Arbitration: load wins a same-edge collision; the count event is deferred one cycle.
  always_comb begin
    load_pulse_nxt = rise[LD];
    count_en_nxt   = pending | (rise[SEN] & ~pause & ~rise[LD]);
    pending_nxt    = rise[SEN] & ~pause & rise[LD];
  end

  // Register stage: synchronizers, FSM state and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= '0;
      s2         <= '0;
      stable     <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      count_en   <= 1'b0;
      load_pulse <= 1'b0;
      state[0]   <= IDLE_LOW;
      state[1]   <= IDLE_LOW;
    end else begin
      s1         <= {load_btn, sensor_in};
      s2         <= s1;
      stable     <= stable_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      count_en   <= count_en_nxt;
      load_pulse <= load_pulse_nxt;
      state[0]   <= state_nxt[0];
      state[1]   <= state_nxt[1];
    end
  end

  assign sensor_level = stable[SEN];

endmodule
